cpu_run_ctrl: RTL and testbench

Synthesizable run controller for the CPU simulation and FPGA bring-up flow: replaces the hand-timed reset pulse and fixed end-of-simulation delay with a parametrised sequencer. Holds up to NUM_CORES cores in reset for a programmable number of cycles, releases them, and tracks per-core halt and retire activity. Ends the run on all-halted, abort, cycle timeout or per-core hang, and raises `sim_end` with a sticky cause. Sits beside `cpu` instances in the top level and in the bench, clocked by the CPU read clock.

---
 rtl/cpu_run_pkg.sv | 19 +
 rtl/run_wdog.sv | 40 ++++
 rtl/cpu_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller.
//   run_state_e : sequencer states
//   CAUSE_*     : bit positions inside the one-hot end-of-run cause vector
package cpu_run_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_END  = 2'd3
  } run_state_e;

  localparam int CAUSE_W       = 4;
  localparam int CAUSE_DONE    = 0;
  localparam int CAUSE_ABORT   = 1;
  localparam int CAUSE_TIMEOUT = 2;
  localparam int CAUSE_HANG    = 3;

endpackage

// File: rtl/run_wdog.sv
// Per-core retire watchdog.
//   clkb   : clock
//   rst    : synchronous active-low reset
//   clr    : clear the idle counter (core not running or halted)
//   en     : count this cycle (controller in RUN)
//   retire : instruction retired this cycle; clears the counter
//   fire   : WDOG_CYCLES consecutive non-retiring cycles reached (combinational)
module run_wdog #(
  parameter int WDOG_CYCLES = 16
) (
  input  logic clkb,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic retire,
  output logic fire
);

  localparam int CW = (WDOG_CYCLES < 1) ? 1 : $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || retire)
      cnt_d = '0;
    else if (en && cnt_q != LAST)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clkb) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // The cycle that would be the WDOG_CYCLES-th idle one fires the watchdog.
  assign fire = (WDOG_CYCLES != 0) && en && !clr && !retire && (cnt_q == LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for CPU simulation / FPGA bring-up.
// Holds the cores in reset, releases them, and ends the run on all-halted,
// abort, cycle timeout or per-core hang, latching a one-hot cause.
//   clkb, rst   : clock, synchronous active-low reset
//   start       : launch / re-arm (IDLE and END only)
//   abort       : operator stop (HOLD and RUN only)
//   halt_i      : per-core halt level
//   retire_i    : per-core instruction-retired pulse
//   core_rst    : active-high reset to the cores
//   running     : state == RUN
//   sim_end     : state == END
//   cause       : sticky one-hot {hang, timeout, abort, done}
//   halted_mask : per-core halt seen in RUN
//   hang_mask   : cores whose watchdog ended the run
//   cycle_cnt   : RUN cycles elapsed (saturating)
module cpu_run_ctrl #(
  parameter int NUM_CORES    = 1,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 20,
  parameter int WDOG_CYCLES  = 16
) (
  input  logic                 clkb,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] halt_i,
  input  logic [NUM_CORES-1:0] retire_i,
  output logic [NUM_CORES-1:0] core_rst,
  output logic                 running,
  output logic                 sim_end,
  output logic [3:0]           cause,
  output logic [NUM_CORES-1:0] halted_mask,
  output logic [NUM_CORES-1:0] hang_mask,
  output logic [CNT_W-1:0]     cycle_cnt
);
  import cpu_run_pkg::*;

  localparam int HW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  run_state_e           state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [NUM_CORES-1:0] halted_q, halted_d;
  logic [NUM_CORES-1:0] hang_q, hang_d;

  logic                 in_run;
  logic [NUM_CORES-1:0] wdog_clr, wdog_fire;
  logic                 all_halted, timeout, arm;

  assign in_run     = (state_q == S_RUN);
  // A halted core is not expected to retire, so its watchdog is held clear.
  assign wdog_clr   = ~{NUM_CORES{in_run}} | halted_q | halt_i;
  assign all_halted = &(halted_q | halt_i);
  assign timeout    = (MAX_CYCLES != 0) && (cnt_q == TO_LAST);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_wdog
    run_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
      .clkb   (clkb),
      .rst    (rst),
      .clr    (wdog_clr[i]),
      .en     (in_run),
      .retire (retire_i[i]),
      .fire   (wdog_fire[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    halted_d = halted_q;
    hang_d   = hang_q;
    arm      = 1'b0;

    case (state_q)
      S_IDLE: arm = start;
      S_HOLD: begin
        if (abort) begin
          state_d              = S_END;
          cause_d[CAUSE_ABORT] = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RUN: begin
        // The terminating cycle is counted too.
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        halted_d = halted_q | halt_i;
        if (all_halted) begin
          state_d             = S_END;
          cause_d[CAUSE_DONE] = 1'b1;
        end else if (abort) begin
          state_d              = S_END;
          cause_d[CAUSE_ABORT] = 1'b1;
        end else if (timeout) begin
          state_d                = S_END;
          cause_d[CAUSE_TIMEOUT] = 1'b1;
        end else if (|wdog_fire) begin
          state_d             = S_END;
          cause_d[CAUSE_HANG] = 1'b1;
          hang_d              = wdog_fire;
        end
      end
      S_END:   arm = start;
      default: state_d = S_IDLE;
    endcase

    // Entering HOLD starts a fresh run; cause is cleared so END sets exactly one bit.
    if (arm) begin
      state_d  = S_HOLD;
      hold_d   = '0;
      cnt_d    = '0;
      cause_d  = '0;
      halted_d = '0;
      hang_d   = '0;
    end
  end

  always_ff @(posedge clkb) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      cnt_q    <= '0;
      cause_q  <= '0;
      halted_q <= '0;
      hang_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      halted_q <= halted_d;
      hang_q   <= hang_d;
    end
  end

  // Cores stay out of reset in END so their state can be inspected.
  assign core_rst    = {NUM_CORES{(state_q == S_IDLE) || (state_q == S_HOLD)}};
  assign running     = in_run;
  assign sim_end     = (state_q == S_END);
  assign cause       = cause_q;
  assign halted_mask = halted_q;
  assign hang_mask   = hang_q;
  assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  logic        clkb = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  halt_i, retire_i;
  logic [1:0]  core_rst, halted_mask, hang_mask;
  logic        running, sim_end;
  logic [3:0]  cause;
  logic [31:0] cycle_cnt;

  typedef struct packed {
    logic [3:0]  cause;
    logic [1:0]  halted;
    logic [1:0]  hang;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  cpu_run_ctrl #(
    .NUM_CORES(2), .CNT_W(32), .RESET_CYCLES(4), .MAX_CYCLES(20), .WDOG_CYCLES(16)
  ) dut (
    .clkb(clkb), .rst(rst), .start(start), .abort(abort),
    .halt_i(halt_i), .retire_i(retire_i), .core_rst(core_rst),
    .running(running), .sim_end(sim_end), .cause(cause),
    .halted_mask(halted_mask), .hang_mask(hang_mask), .cycle_cnt(cycle_cnt)
  );

  always #5 clkb = ~clkb;

  task automatic step();
    @(posedge clkb);
    #1;
  endtask

  // Pulse start and wait (bounded) for running; returns HOLD cycles seen.
  task automatic launch(output int hold);
    start = 1'b1;
    step();
    start = 1'b0;
    hold = 0;
    while (running !== 1'b1 && hold < 50) begin
      hold++;
      step();
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; halt_i = 2'b00; retire_i = 2'b11;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step(); step();
    n_chk++;
    if ({core_rst, running, sim_end, cause, halted_mask, hang_mask, cycle_cnt} !== {2'b11, 1'b0, 1'b0, 4'b0, 2'b0, 2'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h",
               {core_rst, running, sim_end, cause, halted_mask, hang_mask, cycle_cnt},
               {2'b11, 1'b0, 1'b0, 4'b0, 2'b0, 2'b0, 32'd0});
    end
    rst = 1'b1;
    step(); step(); step();
    n_chk++;
    if (core_rst !== 2'b11 || running !== 1'b0 || sim_end !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got core_rst=%b running=%b sim_end=%b want 11 0 0", core_rst, running, sim_end);
    end
  endtask

  task automatic test_timeout(input string tag);
    int h, n;
    exp_t e;
    idle_inputs();
    exp_q.push_back({4'b0100, 2'b00, 2'b00, 32'd20});
    launch(h);
    n_chk++;
    if (h !== 4 || core_rst !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_hold: got hold=%0d core_rst=%b want 4 00", tag, h, core_rst);
    end
    n = 0;
    while (running === 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== 20 || sim_end !== 1'b1 || core_rst !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_run_len: got run=%0d sim_end=%b core_rst=%b want 20 1 00", tag, n, sim_end, core_rst);
    end
    e = exp_q.pop_front();
    n_chk++;
    if ({cause, halted_mask, hang_mask, cycle_cnt} !== e) begin
      n_fail++;
      $display("FAIL %s_result: got %h want %h", tag, {cause, halted_mask, hang_mask, cycle_cnt}, e);
    end
  endtask

  task automatic test_all_halted();
    int h, n;
    exp_t e;
    idle_inputs();
    exp_q.push_back({4'b0001, 2'b11, 2'b00, 32'd10});
    launch(h);
    n = 0;
    while (running === 1'b1 && n < 200) begin
      halt_i = {(n >= 9), (n >= 5)};
      step();
      n++;
    end
    n_chk++;
    if (n !== 10 || sim_end !== 1'b1) begin
      n_fail++;
      $display("FAIL halted_run_len: got run=%0d sim_end=%b want 10 1", n, sim_end);
    end
    e = exp_q.pop_front();
    n_chk++;
    if ({cause, halted_mask, hang_mask, cycle_cnt} !== e) begin
      n_fail++;
      $display("FAIL halted_result: got %h want %h", {cause, halted_mask, hang_mask, cycle_cnt}, e);
    end
  endtask

  task automatic test_hang();
    int h, n;
    exp_t e;
    idle_inputs();
    // core1 idles from run cycle 3; the 16th idle cycle is run cycle 18.
    exp_q.push_back({4'b1000, 2'b00, 2'b10, 32'd19});
    launch(h);
    n = 0;
    while (running === 1'b1 && n < 200) begin
      retire_i = {(n < 3), 1'b1};
      step();
      n++;
    end
    n_chk++;
    if (n !== 19 || sim_end !== 1'b1) begin
      n_fail++;
      $display("FAIL hang_run_len: got run=%0d sim_end=%b want 19 1", n, sim_end);
    end
    e = exp_q.pop_front();
    n_chk++;
    if ({cause, halted_mask, hang_mask, cycle_cnt} !== e) begin
      n_fail++;
      $display("FAIL hang_result: got %h want %h", {cause, halted_mask, hang_mask, cycle_cnt}, e);
    end
  endtask

  task automatic test_done_vs_timeout();
    int h, n;
    exp_t e;
    idle_inputs();
    exp_q.push_back({4'b0001, 2'b11, 2'b00, 32'd20});
    launch(h);
    n = 0;
    while (running === 1'b1 && n < 200) begin
      halt_i = {(n == 19), (n >= 2)};
      step();
      n++;
    end
    e = exp_q.pop_front();
    n_chk++;
    if ({cause, halted_mask, hang_mask, cycle_cnt} !== e || sim_end !== 1'b1) begin
      n_fail++;
      $display("FAIL done_vs_timeout: got %h want %h", {cause, halted_mask, hang_mask, cycle_cnt}, e);
    end
  endtask

  task automatic test_abort_vs_timeout();
    int h, n;
    exp_t e;
    idle_inputs();
    exp_q.push_back({4'b0010, 2'b00, 2'b00, 32'd20});
    launch(h);
    n = 0;
    while (running === 1'b1 && n < 200) begin
      abort = (n == 19);
      step();
      n++;
    end
    abort = 1'b0;
    e = exp_q.pop_front();
    n_chk++;
    if ({cause, halted_mask, hang_mask, cycle_cnt} !== e || sim_end !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_vs_timeout: got %h want %h", {cause, halted_mask, hang_mask, cycle_cnt}, e);
    end
  endtask

  task automatic test_abort_hold();
    exp_t e;
    idle_inputs();
    exp_q.push_back({4'b0010, 2'b00, 2'b00, 32'd0});
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    e = exp_q.pop_front();
    n_chk++;
    if ({cause, halted_mask, hang_mask, cycle_cnt} !== e || sim_end !== 1'b1 || core_rst !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_hold: got %h sim_end=%b core_rst=%b want %h 1 00",
               {cause, halted_mask, hang_mask, cycle_cnt}, sim_end, core_rst, e);
    end
    step();  // abort is ignored in END
    n_chk++;
    if (sim_end !== 1'b1 || cause !== 4'b0010) begin
      n_fail++;
      $display("FAIL abort_in_end: got sim_end=%b cause=%b want 1 0010", sim_end, cause);
    end
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_chk++;
    if (cause !== 4'b0000 || sim_end !== 1'b0 || running !== 1'b0 || core_rst !== 2'b11) begin
      n_fail++;
      $display("FAIL rearm_hold: got cause=%b sim_end=%b running=%b core_rst=%b want 0000 0 0 11",
               cause, sim_end, running, core_rst);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_midrun_reset();
    int h, n;
    idle_inputs();
    launch(h);
    n = 0;
    while (running === 1'b1 && n < 200) begin
      start = (n == 2);
      if (n == 3) begin
        n_chk++;
        if (cycle_cnt !== 32'd3 || core_rst !== 2'b00) begin
          n_fail++;
          $display("FAIL start_in_run: got cycle_cnt=%0d core_rst=%b want 3 00", cycle_cnt, core_rst);
        end
      end
      if (n == 7) rst = 1'b0;
      step();
      n++;
      if (n == 8) break;
    end
    start = 1'b0;
    n_chk++;
    if ({core_rst, running, sim_end, cause, cycle_cnt} !== {2'b11, 1'b0, 1'b0, 4'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h want %h", {core_rst, running, sim_end, cause, cycle_cnt},
               {2'b11, 1'b0, 1'b0, 4'b0, 32'd0});
    end
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_timeout("timeout");
    test_timeout("back_to_back");
    test_all_halted();
    test_hang();
    test_done_vs_timeout();
    test_abort_vs_timeout();
    test_abort_hold();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
